// File: rtl/upsample_stream_loader.sv
// Upsample engine front end: loads one AXI-Stream frame into the input buffer, starts the engine, waits for done.
// Optional UPSAMPLE_LOADER_PERF_EN adds wait-cycle and frame counters.
module upsample_stream_loader #(
  parameter int length = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        size_upsample,
  input  logic [length-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [length-1:0] mem_wdata,
  output logic              up_start,
  input  logic              up_done,
  output logic              frame_done,
`ifdef UPSAMPLE_LOADER_PERF_EN
  output logic [31:0]       perf_wait_cycles,
  output logic [15:0]       perf_frames,
`endif
  output logic              err_tlast
);

  typedef enum logic [1:0] {LOAD, KICK, WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [2:0]        size_q;
  logic [2:0]        size_eff;
  logic [ADDR_W-1:0] last_idx;
  logic              accept;
  logic              final_beat;
  logic              done_seen;

  // The size code is live on the first beat and frozen for the rest of the frame.
  always_comb begin
    size_eff = (count == '0) ? size_upsample : size_q;
    case (size_eff)
      3'd0:    last_idx = ADDR_W'(15);
      3'd1:    last_idx = ADDR_W'(63);
      3'd2:    last_idx = ADDR_W'(255);
      3'd3:    last_idx = ADDR_W'(1023);
      3'd4:    last_idx = ADDR_W'(4095);
      default: last_idx = ADDR_W'(16383);
    endcase
  end

  assign accept     = (state == LOAD) && s_axis_tready && s_axis_tvalid;
  assign final_beat = accept && (count == last_idx);
  // up_start is high only during the first WAIT cycle, so it masks a coincident done.
  assign done_seen  = (state == WAIT) && !up_start && up_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= LOAD;
      count         <= '0;
      size_q        <= '0;
      s_axis_tready <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      up_start      <= 1'b0;
      frame_done    <= 1'b0;
      err_tlast     <= 1'b0;
    end else begin
      mem_we     <= accept;
      up_start   <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        mem_addr  <= count;
        mem_wdata <= s_axis_tdata;
      end
      case (state)
        LOAD: begin
          s_axis_tready <= 1'b1;
          if (accept) begin
            if (count == '0) size_q <= size_upsample;
            if (final_beat) begin
              count         <= '0;
              state         <= KICK;
              s_axis_tready <= 1'b0;
              if (!s_axis_tlast) err_tlast <= 1'b1;
            end else if (s_axis_tlast) begin
              count     <= '0;
              err_tlast <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        KICK: begin
          state    <= WAIT;
          up_start <= 1'b1;
        end
        WAIT: begin
          if (done_seen) begin
            state         <= LOAD;
            frame_done    <= 1'b1;
            s_axis_tready <= 1'b1;
          end
        end
        default: begin
          state         <= LOAD;
          s_axis_tready <= 1'b0;
        end
      endcase
    end
  end

`ifdef UPSAMPLE_LOADER_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_wait_cycles <= '0;
      perf_frames      <= '0;
    end else begin
      if ((state == WAIT) && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 1'b1;
      if (done_seen)
        perf_frames <= perf_frames + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_upsample_stream_loader.sv
// Scoreboard bench for upsample_stream_loader; covers perf counters when UPSAMPLE_LOADER_PERF_EN is defined.
module tb_upsample_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  size_upsample;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        up_start;
  logic        up_done;
  logic        frame_done;
  logic        err_tlast;
`ifdef UPSAMPLE_LOADER_PERF_EN
  logic [31:0] perf_wait_cycles;
  logic [15:0] perf_frames;
`endif

  upsample_stream_loader #(.length(16), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .size_upsample(size_upsample),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .up_start(up_start), .up_done(up_done), .frame_done(frame_done),
`ifdef UPSAMPLE_LOADER_PERF_EN
    .perf_wait_cycles(perf_wait_cycles), .perf_frames(perf_frames),
`endif
    .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_writes = 0;
  int   n_starts = 0;
  int   last_addr = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor: every buffer write must match the oldest accepted beat, one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (sb.size() == 0) begin
          check("spurious_we", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
          check("wr_latency", 32'(cyc), 32'(e.cyc + 1));
        end
        n_writes++;
        last_addr = int'(mem_addr);
      end
      if (up_start) n_starts++;
    end
  end

  task automatic send_frame(input int code, input int nbeats, input int tlast_at,
                            input logic [15:0] base, input int gap_pct, output int last_hs);
    size_upsample = 3'(code);
    last_hs = -1;
    for (int i = 0; i < nbeats; i++) begin
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      s_axis_tdata = base + 16'(i);
      s_axis_tlast = (i == tlast_at);
      while (!acc) begin
        s_axis_tvalid = ($urandom_range(99) >= gap_pct);
        @(negedge clk);
        if (s_axis_tvalid && s_axis_tready) begin
          acc = 1'b1;
          sb.push_back('{cyc, i, base + 16'(i)});
          last_hs = cyc;
        end
        @(posedge clk); #1;
        guard++;
        if (guard > 1000) begin
          check("handshake_timeout", 32'(guard), 32'd0);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_start(output int s);
    bit got;
    got = 1'b0;
    s = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (up_start) begin
        got = 1'b1;
        s = cyc;
        break;
      end
    end
    if (!got) check("up_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fd(output int f);
    bit got;
    got = 1'b0;
    f = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1'b1;
        f = cyc;
        break;
      end
    end
    if (!got) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    check({tag, "_we"},     32'(mem_we),        32'd0);
    check({tag, "_addr"},   32'(mem_addr),      32'd0);
    check({tag, "_wdata"},  32'(mem_wdata),     32'd0);
    check({tag, "_start"},  32'(up_start),      32'd0);
    check({tag, "_fdone"},  32'(frame_done),    32'd0);
    check({tag, "_err"},    32'(err_tlast),     32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("tready_after_reset", 32'(s_axis_tready), 32'd1);
  endtask

  initial begin
    int hs, s, f, w0, st0;
    rst = 1'b0;
    size_upsample = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    up_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    release_reset();

    // Size 0, back-to-back beats, clean tlast.
    send_frame(0, 16, 15, 16'h0100, 0, hs);
    wait_start(s);
    check("t1_start_lat", 32'(s), 32'(hs + 2));
    check("t1_writes", 32'(n_writes), 32'd16);
    check("t1_last_addr", 32'(last_addr), 32'd15);
    repeat (3) begin
      @(negedge clk);
      check("t1_tready_wait", 32'(s_axis_tready), 32'd0);
    end
    up_done = 1'b1;
    wait_fd(f);
    up_done = 1'b0;
    check("t1_tready_after", 32'(s_axis_tready), 32'd1);
    check("t1_err", 32'(err_tlast), 32'd0);
    @(posedge clk); #1;

    // Size 5 (clamped to 128x128), random tvalid gaps.
    w0 = n_writes;
    st0 = n_starts;
    send_frame(5, 16384, 16383, 16'h5A00, 25, hs);
    wait_start(s);
    check("t2_start_lat", 32'(s), 32'(hs + 2));
    check("t2_writes", 32'(n_writes - w0), 32'd16384);
    check("t2_last_addr", 32'(last_addr), 32'h3FFF);
    check("t2_err", 32'(err_tlast), 32'd0);
    repeat (4) @(negedge clk);
    up_done = 1'b1;
    wait_fd(f);
    up_done = 1'b0;
    check("t2_starts", 32'(n_starts - st0), 32'd1);
    @(posedge clk); #1;

    // Size 1, early tlast on beat 10: frame dropped, next frame restarts at 0.
    w0 = n_writes;
    st0 = n_starts;
    send_frame(1, 11, 10, 16'h2000, 0, hs);
    repeat (6) @(negedge clk);
    check("t3_writes", 32'(n_writes - w0), 32'd11);
    check("t3_no_start", 32'(n_starts - st0), 32'd0);
    check("t3_err", 32'(err_tlast), 32'd1);
    check("t3_tready", 32'(s_axis_tready), 32'd1);
    @(posedge clk); #1;
    send_frame(1, 64, 63, 16'h3000, 10, hs);
    wait_start(s);
    check("t3b_start_lat", 32'(s), 32'(hs + 2));
    check("t3b_last_addr", 32'(last_addr), 32'd63);
    up_done = 1'b1;
    wait_fd(f);
    up_done = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame while beat 6 is being written.
    send_frame(0, 7, -1, 16'h4000, 0, hs);
    rst = 1'b0;
    #1 check_reset_outputs("midrst");
    sb.delete();
    release_reset();
    send_frame(0, 16, 15, 16'h4100, 0, hs);
    wait_start(s);
    check("t5_start_lat", 32'(s), 32'(hs + 2));
    check("t5_err", 32'(err_tlast), 32'd0);
    up_done = 1'b1;
    wait_fd(f);
    up_done = 1'b0;
    @(posedge clk); #1;

    // Missing tlast on the final beat; done held from the start cycle.
    send_frame(0, 16, -1, 16'h5000, 0, hs);
    wait_start(s);
    up_done = 1'b1;
    wait_fd(f);
    check("t4_fd_lat", 32'(f), 32'(s + 2));
    check("t4_err", 32'(err_tlast), 32'd1);
    check("t4_tready", 32'(s_axis_tready), 32'd1);
    up_done = 1'b0;
    @(negedge clk);
    check("t4_fd_pulse", 32'(frame_done), 32'd0);
    check("t4_tready_hold", 32'(s_axis_tready), 32'd1);
    @(posedge clk); #1;

`ifdef UPSAMPLE_LOADER_PERF_EN
    rst = 1'b0;
    #1;
    check("perf_rst_wait", perf_wait_cycles, 32'd0);
    check("perf_rst_frames", 32'(perf_frames), 32'd0);
    sb.delete();
    release_reset();
    send_frame(0, 16, 15, 16'h6000, 0, hs);
    wait_start(s);
    repeat (19) @(negedge clk);
    up_done = 1'b1;
    wait_fd(f);
    up_done = 1'b0;
    check("perf_wait_span", 32'(f - s), 32'd20);
    check("perf_wait_cycles", perf_wait_cycles, 32'd20);
    check("perf_frames", 32'(perf_frames), 32'd1);
    @(posedge clk); #1;
`endif

    repeat (5) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
